// File: rtl/ppu_write_scheduler.sv
// ppu_write_scheduler
// Buffers CPU S-type PPU writes in a small FIFO and drains them into the
// single-port PPU memory during vertical blank. Renderer reads always
// take the memory port ahead of buffered writes.
module ppu_write_scheduler #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 10,
  parameter int VAL_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PPU_en,
  input  logic [IDX_W-1:0]           S_type_index,
  input  logic [VAL_W-1:0]           S_type_value,
  output logic                       cpu_stall,
  input  logic                       vblank,
  input  logic                       rend_req,
  input  logic [IDX_W-1:0]           rend_addr,
  output logic                       rend_grant,
  output logic                       mem_we,
  output logic [IDX_W-1:0]           mem_addr,
  output logic [VAL_W-1:0]           mem_wdata,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       drain_done,
  output logic                       overflow,
  output logic                       late
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;

  // FIFO storage; no reset so it maps onto distributed/block RAM.
  logic [IDX_W-1:0] idx_mem [DEPTH];
  logic [VAL_W-1:0] val_mem [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drain_finish;
  logic late_set;

  logic                rend_grant_reg;
  logic                mem_we_reg;
  logic [IDX_W-1:0]    mem_addr_reg;
  logic [VAL_W-1:0]    mem_wdata_reg;
  logic                drain_done_reg;
  logic                overflow_reg;
  logic                late_reg;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  // A write arriving while full is dropped even if a pop frees a slot
  // in the same cycle; the CPU was told to stall.
  assign push  = PPU_en && !full;

  // Occupancy update from this cycle's push/pop pair.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Store an accepted CPU write at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[wr_ptr_reg] <= S_type_index;
      val_mem[wr_ptr_reg] <= S_type_value;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM next state: enter drain on vblank with work queued; leave when
  // the FIFO empties or vblank ends.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (vblank && !empty) state_next = DRAIN;
      DRAIN:   if (!vblank || (count_next == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: pop only in DRAIN when the renderer leaves the port free.
  // The cycle in which vblank is seen low still completes its write.
  always_comb begin
    pop          = 1'b0;
    drain_finish = 1'b0;
    late_set     = 1'b0;
    if (state_reg == DRAIN) begin
      pop          = !rend_req && !empty;
      drain_finish = pop && (count_next == '0) && vblank;
      late_set     = !vblank && (count_next != '0);
    end
  end

  // Registered memory port: renderer first, then FIFO head, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rend_grant_reg <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
    end else begin
      rend_grant_reg <= rend_req;
      mem_we_reg     <= pop;
      if (rend_req) begin
        mem_addr_reg <= rend_addr;
      end else if (pop) begin
        mem_addr_reg  <= idx_mem[rd_ptr_reg];
        mem_wdata_reg <= val_mem[rd_ptr_reg];
      end
    end
  end

  // Status flags: drain_done is a pulse, overflow and late are sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      late_reg       <= 1'b0;
    end else begin
      drain_done_reg <= drain_finish;
      if (PPU_en && full) overflow_reg <= 1'b1;
      if (late_set)       late_reg     <= 1'b1;
    end
  end

  assign cpu_stall  = full;
  assign rend_grant = rend_grant_reg;
  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign fifo_count = count_reg;
  // Masked by vblank so a pulse can never escape into active display.
  assign drain_done = drain_done_reg && vblank;
  assign overflow   = overflow_reg;
  assign late       = late_reg;

endmodule

// File: tb/tb_ppu_write_scheduler.sv
// Scoreboard bench for ppu_write_scheduler: stimulus pushes expected
// memory writes / renderer grants into queues, a negedge monitor pops
// and compares whenever the DUT presents one.
module tb_ppu_write_scheduler;

  localparam int DEPTH = 8;
  localparam int IDX_W = 10;
  localparam int VAL_W = 16;

  typedef struct packed {
    logic [IDX_W-1:0] a;
    logic [VAL_W-1:0] d;
  } wr_t;

  logic                   clk;
  logic                   rst;
  logic                   PPU_en;
  logic [IDX_W-1:0]       S_type_index;
  logic [VAL_W-1:0]       S_type_value;
  logic                   cpu_stall;
  logic                   vblank;
  logic                   rend_req;
  logic [IDX_W-1:0]       rend_addr;
  logic                   rend_grant;
  logic                   mem_we;
  logic [IDX_W-1:0]       mem_addr;
  logic [VAL_W-1:0]       mem_wdata;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   drain_done;
  logic                   overflow;
  logic                   late;

  ppu_write_scheduler #(.DEPTH(DEPTH), .IDX_W(IDX_W), .VAL_W(VAL_W)) dut (
    .clk(clk), .rst(rst), .PPU_en(PPU_en), .S_type_index(S_type_index),
    .S_type_value(S_type_value), .cpu_stall(cpu_stall), .vblank(vblank),
    .rend_req(rend_req), .rend_addr(rend_addr), .rend_grant(rend_grant),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fifo_count(fifo_count), .drain_done(drain_done), .overflow(overflow),
    .late(late)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int grant_cnt = 0;
  int done_cnt = 0;
  int last_wr_cyc = 0;
  int prev_wr_cyc = 0;

  wr_t              exp_q[$];
  logic [IDX_W-1:0] grant_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        wr_t e;
        wr_cnt++;
        prev_wr_cyc = last_wr_cyc;
        last_wr_cyc = cyc;
        $display("write addr=0x%03h data=0x%04h", mem_addr, mem_wdata);
        check("we_with_grant", {31'd0, rend_grant}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=0x%0h/0x%0h required=none", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(mem_addr), 32'(e.a));
          check("write_data", 32'(mem_wdata), 32'(e.d));
        end
      end
      if (rend_grant) begin
        grant_cnt++;
        $display("grant addr=0x%03h", mem_addr);
        if (grant_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant actual=0x%0h required=none", mem_addr);
        end else begin
          check("grant_addr", 32'(mem_addr), 32'(grant_q.pop_front()));
        end
      end
      if (drain_done) begin
        done_cnt++;
        $display("drain_done");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IDX_W-1:0] a, input logic [VAL_W-1:0] d, input bit accept);
    wr_t e;
    PPU_en = 1'b1;
    S_type_index = a;
    S_type_value = d;
    tick();
    PPU_en = 1'b0;
    if (accept) begin
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_count != 0) && n < 100) begin
      tick();
      n++;
    end
    check(name, {31'd0, (n >= 100)}, 32'd0);
    tick();
    tick();
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_flags"}, {26'd0, cpu_stall, rend_grant, mem_we, drain_done, overflow, late}, 32'd0);
    check({name, "_addr"}, 32'(mem_addr), 32'd0);
    check({name, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({name, "_count"}, 32'(fifo_count), 32'd0);
  endtask

  initial begin
    int w0, d0, g0, n;
    rst = 1'b1;
    PPU_en = 1'b0;
    S_type_index = '0;
    S_type_value = '0;
    vblank = 1'b0;
    rend_req = 1'b0;
    rend_addr = '0;

    // Reset then idle
    tick();
    tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick(); tick(); tick();
    check_idle_outputs("idle");

    // Basic drain
    push(10'h005, 16'hBEEF, 1'b1);
    push(10'h006, 16'h1234, 1'b1);
    check("basic_count", 32'(fifo_count), 32'd2);
    d0 = done_cnt;
    w0 = wr_cnt;
    vblank = 1'b1;
    wait_empty("basic_timeout");
    check("basic_writes", 32'(wr_cnt - w0), 32'd2);
    check("basic_consecutive", 32'(last_wr_cyc - prev_wr_cyc), 32'd1);
    check("basic_done", 32'(done_cnt - d0), 32'd1);
    check("basic_count_end", 32'(fifo_count), 32'd0);
    vblank = 1'b0;
    tick();

    // Full / overflow
    for (int i = 0; i < DEPTH; i++) push(10'(12'h100 + i), 16'(16'hA000 + i), 1'b1);
    check("full_stall", {31'd0, cpu_stall}, 32'd1);
    check("full_count", 32'(fifo_count), 32'd8);
    check("pre_overflow", {31'd0, overflow}, 32'd0);
    push(10'h1FF, 16'hDEAD, 1'b0);
    check("overflow_set", {31'd0, overflow}, 32'd1);
    check("overflow_count", 32'(fifo_count), 32'd8);
    w0 = wr_cnt;
    vblank = 1'b1;
    wait_empty("full_timeout");
    check("full_writes", 32'(wr_cnt - w0), 32'd8);
    check("full_stall_clear", {31'd0, cpu_stall}, 32'd0);
    vblank = 1'b0;
    tick();

    // Renderer priority
    for (int i = 0; i < 4; i++) push(10'(12'h040 + i), 16'(16'h5500 + i), 1'b1);
    w0 = wr_cnt;
    g0 = grant_cnt;
    vblank = 1'b1;
    tick();
    tick();
    rend_req = 1'b1;
    rend_addr = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      grant_q.push_back(10'h3FF);
      tick();
    end
    rend_req = 1'b0;
    wait_empty("rend_timeout");
    check("rend_grants", 32'(grant_cnt - g0), 32'd3);
    check("rend_writes", 32'(wr_cnt - w0), 32'd4);
    check("rend_grant_q", 32'(grant_q.size()), 32'd0);
    vblank = 1'b0;
    tick();

    // Late frame
    check("pre_late", {31'd0, late}, 32'd0);
    for (int i = 0; i < 6; i++) push(10'(12'h200 + i), 16'(16'hC000 + i), 1'b1);
    w0 = wr_cnt;
    vblank = 1'b1;
    tick(); tick(); tick();
    vblank = 1'b0;
    tick(); tick(); tick();
    check("late_writes", 32'(wr_cnt - w0), 32'd3);
    check("late_set", {31'd0, late}, 32'd1);
    check("late_count", 32'(fifo_count), 32'd3);
    d0 = done_cnt;
    vblank = 1'b1;
    wait_empty("late_timeout");
    check("late_writes_total", 32'(wr_cnt - w0), 32'd6);
    check("late_done", 32'(done_cnt - d0), 32'd1);
    check("late_sticky", {31'd0, late}, 32'd1);
    check("overflow_sticky", {31'd0, overflow}, 32'd1);
    vblank = 1'b0;
    tick();

    // Async reset mid-drain
    for (int i = 0; i < 4; i++) push(10'(12'h300 + i), 16'(16'h7700 + i), 1'b1);
    vblank = 1'b1;
    n = 0;
    while (!mem_we && n < 20) begin
      tick();
      n++;
    end
    check("arst_wait_timeout", {31'd0, (n >= 20)}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_we", {31'd0, mem_we}, 32'd0);
    check("arst_count", 32'(fifo_count), 32'd0);
    check("arst_flags", {30'd0, overflow, late}, 32'd0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    w0 = wr_cnt;
    for (int i = 0; i < 10; i++) tick();
    check("arst_no_writes", 32'(wr_cnt - w0), 32'd0);
    check("arst_count_after", 32'(fifo_count), 32'd0);
    vblank = 1'b0;
    tick();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_write_scheduler.md
Name: ppu_write_scheduler

Overview:
- Sits between the CPU's S-type PPU write port (PPU_en / S_type_index / S_type_value) and the single-port PPU object/tile memory.
- Buffers CPU writes in a small FIFO so the CPU never collides with the renderer.
- Drains the buffered writes into PPU memory only during vertical blank.
- Arbitrates the memory port between renderer reads and buffered writes; the renderer always wins.

Parameters:
DEPTH, 8, FIFO entries (power of two, >= 2)
IDX_W, 10, PPU memory address width (matches S_type_index)
VAL_W, 16, PPU memory data width (matches S_type_value)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
PPU_en  in  1  CPU write strobe, one write per cycle asserted
S_type_index  in  IDX_W  CPU write address
S_type_value  in  VAL_W  CPU write data
cpu_stall  out  1  FIFO full; CPU must hold its write
vblank  in  1  level, high during vertical blank
rend_req  in  1  renderer read request this cycle
rend_addr  in  IDX_W  renderer read address
rend_grant  out  1  registered; memory port driven for renderer this cycle
mem_we  out  1  registered write enable to PPU memory
mem_addr  out  IDX_W  registered memory address
mem_wdata  out  VAL_W  registered memory write data
fifo_count  out  $clog2(DEPTH)+1  current occupancy
drain_done  out  1  one-cycle pulse when FIFO empties during vblank
overflow  out  1  sticky: a push was attempted while full
late  out  1  sticky: vblank fell while FIFO non-empty

Behaviour:
- Reset (async, rst=1): FIFO pointers and count = 0; state = IDLE; cpu_stall=0, rend_grant=0, mem_we=0, mem_addr=0, mem_wdata=0, drain_done=0, overflow=0, late=0. Reset mid-drain discards all queued writes, and no partial write is issued after reset.
- Push: when PPU_en=1 and count<DEPTH, {index,value} is stored at the write pointer.
- Push while full: when PPU_en=1 and count==DEPTH, the write is dropped and overflow is set. This holds even when a pop occurs the same cycle.
- cpu_stall = (count==DEPTH), combinational from count.
- Pointers wrap modulo DEPTH. Simultaneous push and pop with 0<count<DEPTH leaves count unchanged.
- FSM (registered):
  - IDLE: if vblank=1 and count>0, go to DRAIN; else stay.
  - DRAIN: each cycle, if rend_req=1, serve the renderer and hold the FIFO. Else pop one entry and issue a write. Exit conditions:
    - popping the last entry (count==1, no push that cycle): go to IDLE, pulse drain_done the following cycle.
    - vblank falls with count>0: go to IDLE, set late; remaining entries wait for the next vblank.
- Memory port, resolved each cycle with results registered (valid one cycle later):
  - priority 1: rend_req=1 gives rend_grant=1, mem_we=0, mem_addr=rend_addr. This applies in any state.
  - priority 2: state DRAIN and FIFO non-empty gives mem_we=1, mem_addr/mem_wdata = FIFO head; the head is popped.
  - otherwise: rend_grant=0, mem_we=0; mem_addr/mem_wdata hold their previous values.
- Latency:
  - CPU push to memory write takes at minimum 2 cycles (push, pop, registered output), provided vblank is high and the renderer is idle.
  - Renderer request to rend_grant takes 1 cycle.
- Ordering: writes reach memory in CPU issue order. Consecutive writes to the same index are not merged.
- A push into an empty FIFO in the same cycle the FSM checks it is not popped that cycle; the pop occurs the next cycle (no FIFO bypass).
- drain_done is never asserted outside vblank. late and overflow clear only on rst.

Test Plan:
- Reset then idle: rst high for 2 cycles -> every output 0, fifo_count=0; rst low with no stimulus -> all outputs stay 0.
- Basic drain:
  - stimulus: vblank=0, push (0x005,0xBEEF) then (0x006,0x1234); raise vblank with rend_req=0.
  - required: mem_we pulses on two consecutive cycles with addr 0x005/0x006 and data 0xBEEF/0x1234 in order; drain_done pulses once; fifo_count=0.
- Full/overflow:
  - stimulus: vblank=0, push 9 writes with DEPTH=8.
  - required: cpu_stall=1 after the 8th push; 9th write dropped, overflow=1; after vblank exactly 8 writes are issued.
- Renderer priority:
  - stimulus: during a drain of 4 entries, hold rend_req=1 with rend_addr=0x3FF for 3 cycles.
  - required: rend_grant=1 and mem_we=0 with mem_addr=0x3FF for those 3 cycles; the remaining writes resume afterwards, order preserved.
- Late frame:
  - stimulus: queue 6 entries; vblank high for 3 cycles with rend_req=0.
  - required: 3 writes issued, late=1, fifo_count=3; the next vblank issues the remaining 3.
- Async reset mid-drain:
  - stimulus: assert rst between clock edges while mem_we=1.
  - required: mem_we drops immediately, fifo_count=0, and no further writes occur after release.
